// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Optional feature macro: MEM_STAGE_STALLCNT_EN (adds a saturating stall-cycle counter).
package mem_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned STALLCNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Control values written into MEM/WB when no instruction retires this cycle
    localparam logic BUBBLE_REG_WRITE = 1'b0;
    localparam logic BUBBLE_MEMTO_REG = 1'b0;

    typedef struct packed {
        logic              reg_write;
        logic              memto_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  write_reg;
    } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, data-memory handshake, branch redirect and MEM/WB outputs of the MEM stage.
// Optional feature macro: MEM_STAGE_STALLCNT_EN (adds stall_cycles).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              in_RegWrite;
    logic              in_MemtoReg;
    logic              in_MemWrite;
    logic              in_Branch;
    logic              in_zero;
    logic [DATA_W-1:0] in_ALUOut;
    logic [DATA_W-1:0] in_WriteData;
    logic [DATA_W-1:0] in_PCBranch;
    logic [REG_W-1:0]  in_WriteReg;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              PCSrc;
    logic [DATA_W-1:0] PCTarget;
    logic              stall;

    logic              RegWrite;
    logic              MemtoReg;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALUOut;
    logic [REG_W-1:0]  WriteReg;
`ifdef MEM_STAGE_STALLCNT_EN
    logic [STALLCNT_W-1:0] stall_cycles;
`endif

    // Pipeline/memory side driving the stage
    modport master (
        output in_RegWrite, in_MemtoReg, in_MemWrite, in_Branch, in_zero,
        output in_ALUOut, in_WriteData, in_PCBranch, in_WriteReg,
        output mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  PCSrc, PCTarget, stall,
        input  RegWrite, MemtoReg, ReadData, ALUOut, WriteReg
`ifdef MEM_STAGE_STALLCNT_EN
        , input stall_cycles
`endif
    );

    // The MEM stage itself
    modport slave (
        input  in_RegWrite, in_MemtoReg, in_MemWrite, in_Branch, in_zero,
        input  in_ALUOut, in_WriteData, in_PCBranch, in_WriteReg,
        input  mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output PCSrc, PCTarget, stall,
        output RegWrite, MemtoReg, ReadData, ALUOut, WriteReg
`ifdef MEM_STAGE_STALLCNT_EN
        , output stall_cycles
`endif
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction or inserts a bubble.
// Bubbles clear only the controls; data fields hold their last values.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   keep_rdata,
    input  memwb_t d,
    output memwb_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q.reg_write <= d.reg_write;
            q.memto_reg <= d.memto_reg;
            q.alu_out   <= d.alu_out;
            q.write_reg <= d.write_reg;
            // Non-memory instructions leave the last load data in place
            if (!keep_rdata) begin
                q.read_data <= d.read_data;
            end
        end else begin
            q.reg_write <= BUBBLE_REG_WRITE;
            q.memto_reg <= BUBBLE_MEMTO_REG;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access with wait-state handshake, branch resolve, MEM/WB output.
// Optional feature macro: MEM_STAGE_STALLCNT_EN (saturating 16-bit stall_cycles output).
module mem_stage
    import mem_stage_pkg::*;
(
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);

    state_t            state;
    logic              access;
    logic              lat_we;
    logic              lat_reg_write;
    logic              lat_memto_reg;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [REG_W-1:0]  lat_write_reg;

    logic              wb_load;
    logic              wb_keep_rdata;
    memwb_t            wb_d;
    memwb_t            wb_q;

    assign access = bus.in_MemtoReg | bus.in_MemWrite;

    // State and request latch; the latch freezes a request that could not complete at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_memto_reg <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_write_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !bus.mem_ready) begin
                        state         <= WAIT;
                        lat_we        <= bus.in_MemWrite;
                        lat_reg_write <= bus.in_RegWrite;
                        lat_memto_reg <= bus.in_MemtoReg;
                        lat_addr      <= bus.in_ALUOut;
                        lat_wdata     <= bus.in_WriteData;
                        lat_write_reg <= bus.in_WriteReg;
                    end
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request, stall, branch and MEM/WB select; everything is forced quiet while reset is held
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.stall         = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.PCTarget      = '0;
        wb_load           = 1'b0;
        wb_keep_rdata     = 1'b0;
        wb_d.reg_write    = bus.in_RegWrite;
        wb_d.memto_reg    = bus.in_MemtoReg;
        wb_d.read_data    = bus.mem_rdata;
        wb_d.alu_out      = bus.in_ALUOut;
        wb_d.write_reg    = bus.in_WriteReg;

        if (!rst) begin
            bus.PCTarget = bus.in_PCBranch;
            case (state)
                IDLE: begin
                    bus.PCSrc = bus.in_Branch & bus.in_zero;
                    if (access) begin
                        bus.mem_req   = 1'b1;
                        bus.mem_we    = bus.in_MemWrite;
                        bus.mem_addr  = bus.in_ALUOut;
                        bus.mem_wdata = bus.in_WriteData;
                        if (bus.mem_ready) begin
                            wb_load = 1'b1;
                        end else begin
                            bus.stall = 1'b1;
                        end
                    end else begin
                        wb_load       = 1'b1;
                        wb_keep_rdata = 1'b1;
                    end
                end
                WAIT: begin
                    bus.mem_req    = 1'b1;
                    bus.mem_we     = lat_we;
                    bus.mem_addr   = lat_addr;
                    bus.mem_wdata  = lat_wdata;
                    wb_d.reg_write = lat_reg_write;
                    wb_d.memto_reg = lat_memto_reg;
                    wb_d.alu_out   = lat_addr;
                    wb_d.write_reg = lat_write_reg;
                    if (bus.mem_ready) begin
                        wb_load = 1'b1;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (wb_load),
        .keep_rdata (wb_keep_rdata),
        .d          (wb_d),
        .q          (wb_q)
    );

    assign bus.RegWrite = wb_q.reg_write;
    assign bus.MemtoReg = wb_q.memto_reg;
    assign bus.ReadData = wb_q.read_data;
    assign bus.ALUOut   = wb_q.alu_out;
    assign bus.WriteReg = wb_q.write_reg;

`ifdef MEM_STAGE_STALLCNT_EN
    logic [STALLCNT_W-1:0] stall_cnt;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.stall && (stall_cnt != {STALLCNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALLCNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model plus directed vectors.
// Build with MEM_STAGE_STALLCNT_EN defined to also cover the stall counter.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_stage_if bus ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction at most, plus the expected MEM/WB contents
    bit          m_busy  = 1'b0;
    logic        m_we    = 1'b0;
    logic        m_rw    = 1'b0;
    logic        m_m2r   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [4:0]  m_wreg  = '0;
    logic        e_rw    = 1'b0;
    logic        e_m2r   = 1'b0;
    logic [31:0] e_rd    = '0;
    logic [31:0] e_alu   = '0;
    logic [4:0]  e_wreg  = '0;
    int          e_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        logic        t_we, t_rw, t_m2r;
        logic [31:0] t_addr, t_wdata;
        logic [4:0]  t_wreg;
        if (rst) begin
            m_busy <= 1'b0; m_we <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_wreg <= '0;
            e_rw <= 1'b0; e_m2r <= 1'b0; e_rd <= '0; e_alu <= '0; e_wreg <= '0;
            e_cnt <= 0;
        end else begin
            t_we    = m_busy ? m_we    : bus.in_MemWrite;
            t_rw    = m_busy ? m_rw    : bus.in_RegWrite;
            t_m2r   = m_busy ? m_m2r   : bus.in_MemtoReg;
            t_addr  = m_busy ? m_addr  : bus.in_ALUOut;
            t_wdata = m_busy ? m_wdata : bus.in_WriteData;
            t_wreg  = m_busy ? m_wreg  : bus.in_WriteReg;
            if (!m_busy && !(bus.in_MemtoReg || bus.in_MemWrite)) begin
                e_rw <= t_rw; e_m2r <= t_m2r; e_alu <= t_addr; e_wreg <= t_wreg;
            end else if (bus.mem_ready) begin
                e_rw <= t_rw; e_m2r <= t_m2r; e_alu <= t_addr; e_wreg <= t_wreg;
                e_rd <= bus.mem_rdata;
                m_busy <= 1'b0;
            end else begin
                e_rw <= 1'b0; e_m2r <= 1'b0;
                e_cnt <= (e_cnt < 65535) ? e_cnt + 1 : 65535;
                m_busy <= 1'b1;
                m_we <= t_we; m_rw <= t_rw; m_m2r <= t_m2r;
                m_addr <= t_addr; m_wdata <= t_wdata; m_wreg <= t_wreg;
            end
        end
    end

    // Every falling edge: DUT outputs against the model
    always @(negedge clk) begin
        logic        x_req, x_we;
        logic [31:0] x_addr, x_wdata;
        x_req   = !rst && (m_busy || bus.in_MemtoReg || bus.in_MemWrite);
        x_we    = m_busy ? m_we    : bus.in_MemWrite;
        x_addr  = m_busy ? m_addr  : bus.in_ALUOut;
        x_wdata = m_busy ? m_wdata : bus.in_WriteData;
        check("mem_req", 32'(bus.mem_req), 32'(x_req));
        check("stall", 32'(bus.stall), 32'(x_req && !bus.mem_ready));
        check("PCSrc", 32'(bus.PCSrc), 32'(!rst && !m_busy && bus.in_Branch && bus.in_zero));
        if (!m_busy) check("PCTarget", bus.PCTarget, rst ? 32'h0 : bus.in_PCBranch);
        if (x_req) begin
            check("mem_we", 32'(bus.mem_we), 32'(x_we));
            check("mem_addr", bus.mem_addr, x_addr);
            check("mem_wdata", bus.mem_wdata, x_wdata);
        end
        check("RegWrite", 32'(bus.RegWrite), 32'(e_rw));
        check("MemtoReg", 32'(bus.MemtoReg), 32'(e_m2r));
        check("ReadData", bus.ReadData, e_rd);
        check("ALUOut", bus.ALUOut, e_alu);
        check("WriteReg", 32'(bus.WriteReg), 32'(e_wreg));
`ifdef MEM_STAGE_STALLCNT_EN
        check("stall_cycles", 32'(bus.stall_cycles), 32'(e_cnt));
`endif
    end

    task automatic idle_in();
        bus.in_RegWrite  = 1'b0;
        bus.in_MemtoReg  = 1'b0;
        bus.in_MemWrite  = 1'b0;
        bus.in_Branch    = 1'b0;
        bus.in_zero      = 1'b0;
        bus.in_ALUOut    = '0;
        bus.in_WriteData = '0;
        bus.in_PCBranch  = '0;
        bus.in_WriteReg  = '0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_in();
        bus.in_RegWrite  = 1'b1;
        bus.in_MemtoReg  = 1'b1;
        bus.in_MemWrite  = 1'b0;
        bus.in_Branch    = 1'b1;
        bus.in_zero      = 1'b1;
        bus.in_ALUOut    = $urandom;
        bus.in_WriteData = $urandom;
        bus.in_PCBranch  = $urandom;
        bus.in_WriteReg  = 5'd31;
        bus.mem_rdata    = $urandom;
    endtask

    initial begin
        int stall_seen;
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Non-access instruction; mem_ready without a request must not touch ReadData
        bus.in_RegWrite = 1'b1; bus.in_ALUOut = 32'h77; bus.in_WriteReg = 5'd3;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
        next_cycle();
        check("alu_pass_RegWrite", 32'(bus.RegWrite), 32'h1);
        check("alu_pass_ReadData", bus.ReadData, 32'h0);

        // Reset asserted mid-cycle with a load and a branch presented
        idle_in();
        bus.in_MemtoReg = 1'b1; bus.in_ALUOut = 32'h80;
        bus.in_Branch = 1'b1; bus.in_zero = 1'b1; bus.in_PCBranch = 32'h44;
        @(negedge clk); #2 rst = 1'b1; #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_PCSrc", 32'(bus.PCSrc), 32'h0);
        check("rst_RegWrite", 32'(bus.RegWrite), 32'h0);
        check("rst_ALUOut", bus.ALUOut, 32'h0);
        check("rst_WriteReg", 32'(bus.WriteReg), 32'h0);
        next_cycle();
        rst = 1'b0;
        idle_in();

        // Zero-wait load
        bus.in_MemtoReg = 1'b1; bus.in_RegWrite = 1'b1; bus.in_ALUOut = 32'h100;
        bus.in_WriteReg = 5'd5; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk); #1;
        check("zw_mem_req", 32'(bus.mem_req), 32'h1);
        check("zw_stall", 32'(bus.stall), 32'h0);
        next_cycle();
        check("zw_ReadData", bus.ReadData, 32'hDEADBEEF);
        check("zw_WriteReg", 32'(bus.WriteReg), 32'h5);
        check("zw_RegWrite", 32'(bus.RegWrite), 32'h1);
        check("zw_MemtoReg", 32'(bus.MemtoReg), 32'h1);
        idle_in();

        // Store with three wait cycles, inputs scrambled while waiting
        bus.in_MemWrite = 1'b1; bus.in_ALUOut = 32'h40; bus.in_WriteData = 32'h1234;
        stall_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) garbage_in();
            bus.mem_ready = 1'b0;
            @(negedge clk); #1;
            if (bus.stall) stall_seen++;
            check("st_mem_addr", bus.mem_addr, 32'h40);
            check("st_mem_wdata", bus.mem_wdata, 32'h1234);
            check("st_mem_we", 32'(bus.mem_we), 32'h1);
            if (i > 0) check("wait_PCSrc", 32'(bus.PCSrc), 32'h0);
            next_cycle();
        end
        garbage_in();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE0000;
        @(negedge clk); #1;
        check("st_done_stall", 32'(bus.stall), 32'h0);
        check("st_stall_len", 32'(stall_seen), 32'h3);
        next_cycle();
        check("st_RegWrite", 32'(bus.RegWrite), 32'h0);
        check("st_MemtoReg", 32'(bus.MemtoReg), 32'h0);
        check("st_ReadData", bus.ReadData, 32'hCAFE0000);
`ifdef MEM_STAGE_STALLCNT_EN
        check("st_stall_cycles", 32'(bus.stall_cycles), 32'h3);
`endif
        idle_in();

        // Branch taken, then not taken
        bus.in_Branch = 1'b1; bus.in_zero = 1'b1; bus.in_PCBranch = 32'h200;
        @(negedge clk); #1;
        check("br_PCSrc", 32'(bus.PCSrc), 32'h1);
        check("br_PCTarget", bus.PCTarget, 32'h200);
        next_cycle();
        bus.in_zero = 1'b0;
        @(negedge clk); #1;
        check("brnt_PCSrc", 32'(bus.PCSrc), 32'h0);
        next_cycle();
        idle_in();

        // Reset while a load is waiting: the load is abandoned
        bus.in_MemtoReg = 1'b1; bus.in_RegWrite = 1'b1; bus.in_ALUOut = 32'h300;
        bus.in_WriteReg = 5'd9;
        next_cycle();
        @(negedge clk); #2 rst = 1'b1; #1;
        check("rstw_mem_req", 32'(bus.mem_req), 32'h0);
        check("rstw_stall", 32'(bus.stall), 32'h0);
        next_cycle();
        rst = 1'b0;
        idle_in();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555;
        next_cycle();
        check("rstw_ReadData", bus.ReadData, 32'h0);
        check("rstw_WriteReg", 32'(bus.WriteReg), 32'h0);
        check("rstw_RegWrite", 32'(bus.RegWrite), 32'h0);
        idle_in();

        // Back-to-back: zero-wait load, one-wait load, zero-wait store
        bus.in_MemtoReg = 1'b1; bus.in_RegWrite = 1'b1; bus.in_ALUOut = 32'h10;
        bus.in_WriteReg = 5'd1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA;
        next_cycle();
        bus.in_ALUOut = 32'h14; bus.in_WriteReg = 5'd2; bus.mem_ready = 1'b0;
        next_cycle();
        check("b2b_A_ReadData", bus.ReadData, 32'hA);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hB;
        next_cycle();
        check("b2b_B_ReadData", bus.ReadData, 32'hB);
        check("b2b_B_WriteReg", 32'(bus.WriteReg), 32'h2);
        idle_in();
        bus.in_MemWrite = 1'b1; bus.in_ALUOut = 32'h18; bus.in_WriteData = 32'hC;
        bus.mem_ready = 1'b1;
        @(negedge clk); #1;
        check("b2b_C_addr", bus.mem_addr, 32'h18);
        next_cycle();
        idle_in();

`ifdef MEM_STAGE_STALLCNT_EN
        // Long stall saturates the counter
        bus.in_MemtoReg = 1'b1; bus.in_ALUOut = 32'h500;
        repeat (65540) @(posedge clk);
        #1;
        check("sat_stall_cycles", 32'(bus.stall_cycles), 32'hFFFF);
        bus.mem_ready = 1'b1;
        next_cycle();
        idle_in();
`endif

        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
